// File: rtl/csa_job_port.sv
// csa_job_port
//   Host-side endpoint of the CSA job/result FIFO pair. The host fills five
//   job staging registers and commits them. The block then pushes the record
//   into the CSA input FIFO. Seven-word result records are drained from the
//   CSA output FIFO into result registers, where the host reads them back.
//   Optional macro CSA_JOB_PORT_CNT_EN adds JOBS_PUSHED / RESULTS_POPPED
//   counters at addresses 15 / 16.
// Ports
//   axi_mm_clk, rst_n     clock, synchronous active-low reset
//   i_wen/i_waddr/i_wdata/i_wstrb   register write port (wstrb: staging only)
//   i_ren/i_raddr, o_rdata          register read port, data 1 cycle after ren
//   i_job_w_ready, o_job_wen, o_job_wdata       input FIFO push side
//   i_res_r_ready, o_res_ren, i_res_rdata       output FIFO pop side
module csa_job_port #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int OPT_MEM_ADDR_BITS = 10,
  parameter int JOB_WORDS         = 5,
  parameter int RESULT_WORDS      = 7
) (
  input  logic                          axi_mm_clk,
  input  logic                          rst_n,
  input  logic                          i_wen,
  input  logic [OPT_MEM_ADDR_BITS-1:0]  i_waddr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                          i_ren,
  input  logic [OPT_MEM_ADDR_BITS-1:0]  i_raddr,
  output logic [AXI_DATA_WIDTH-1:0]     o_rdata,
  input  logic                          i_job_w_ready,
  output logic                          o_job_wen,
  output logic [AXI_DATA_WIDTH-1:0]     o_job_wdata,
  input  logic                          i_res_r_ready,
  output logic                          o_res_ren,
  input  logic [AXI_DATA_WIDTH-1:0]     i_res_rdata
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int TXW   = $clog2(JOB_WORDS + 1);
  localparam int RXW   = $clog2(RESULT_WORDS + 1);
  localparam int CIW   = $clog2(RESULT_WORDS);

  localparam logic [OPT_MEM_ADDR_BITS-1:0] ADDR_COMMIT = OPT_MEM_ADDR_BITS'(JOB_WORDS);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] ADDR_STATUS = OPT_MEM_ADDR_BITS'(JOB_WORDS + 1);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] ADDR_POP    = OPT_MEM_ADDR_BITS'(JOB_WORDS + 2);
`ifdef CSA_JOB_PORT_CNT_EN
  localparam logic [OPT_MEM_ADDR_BITS-1:0] ADDR_CNT_JOBS =
    OPT_MEM_ADDR_BITS'(JOB_WORDS + 3 + RESULT_WORDS);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] ADDR_CNT_RES =
    OPT_MEM_ADDR_BITS'(JOB_WORDS + 4 + RESULT_WORDS);
`endif

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_WAIT = 2'd1;
  localparam logic [1:0] TX_PUSH = 2'd2;
  localparam logic       RX_IDLE = 1'b0;
  localparam logic       RX_READ = 1'b1;

  localparam logic [TXW-1:0] TX_LAST = TXW'(JOB_WORDS);
  localparam logic [RXW-1:0] RX_ISS  = RXW'(RESULT_WORDS);
  localparam logic [CIW-1:0] RX_LAST = CIW'(RESULT_WORDS - 1);

  logic [AXI_DATA_WIDTH-1:0] r_stage  [JOB_WORDS];
  logic [AXI_DATA_WIDTH-1:0] r_shadow [JOB_WORDS];
  logic [AXI_DATA_WIDTH-1:0] r_result [RESULT_WORDS];
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [AXI_DATA_WIDTH-1:0] r_job_wdata;
  logic [1:0]                r_tx_state;
  logic [TXW-1:0]            r_tx_idx;
  logic                      r_job_wen;
  logic                      r_ovf;
  logic                      r_rx_state;
  logic [RXW-1:0]            r_rx_iss;
  logic [CIW-1:0]            r_cap_idx;
  logic                      r_cap;
  logic                      r_res_ren;
  logic                      r_res_valid;
`ifdef CSA_JOB_PORT_CNT_EN
  logic [AXI_DATA_WIDTH-1:0] r_cnt_jobs;
  logic [AXI_DATA_WIDTH-1:0] r_cnt_res;
`endif

  logic                      w_commit;
  logic                      w_w1c;
  logic                      w_pop_ok;
  logic                      w_tx_busy;
  logic                      w_push_done;
  logic [AXI_DATA_WIDTH-1:0] w_rdata;

  assign w_commit    = i_wen && (i_waddr == ADDR_COMMIT);
  assign w_w1c       = i_wen && (i_waddr == ADDR_STATUS) && i_wdata[3];
  assign w_pop_ok    = i_wen && (i_waddr == ADDR_POP) && r_res_valid;
  assign w_tx_busy   = (r_tx_state != TX_IDLE);
  assign w_push_done = (r_tx_state == TX_PUSH) && (r_tx_idx == TX_LAST);

  assign o_rdata     = r_rdata;
  assign o_job_wen   = r_job_wen;
  assign o_job_wdata = r_job_wdata;
  assign o_res_ren   = r_res_ren;

  // Staging registers, byte-masked host writes
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      for (int k = 0; k < JOB_WORDS; k++) r_stage[k] <= '0;
    end else if (i_wen) begin
      for (int k = 0; k < JOB_WORDS; k++)
        if (i_waddr == OPT_MEM_ADDR_BITS'(k))
          for (int b = 0; b < BYTES; b++)
            if (i_wstrb[b]) r_stage[k][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // TX: snapshot staging on commit, wait for FIFO room, push the record
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_idx    <= '0;
      r_job_wen   <= 1'b0;
      r_job_wdata <= '0;
      r_ovf       <= 1'b0;
      for (int k = 0; k < JOB_WORDS; k++) r_shadow[k] <= '0;
    end else begin
      if (w_commit && w_tx_busy) r_ovf <= 1'b1;
      else if (w_w1c)            r_ovf <= 1'b0;
      case (r_tx_state)
        TX_IDLE: if (w_commit) begin
          r_shadow   <= r_stage;
          r_tx_state <= TX_WAIT;
        end
        TX_WAIT: if (i_job_w_ready) begin
          r_job_wen   <= 1'b1;
          r_job_wdata <= r_shadow[0];
          r_tx_idx    <= TXW'(1);
          r_tx_state  <= TX_PUSH;
        end
        TX_PUSH: if (r_tx_idx != TX_LAST) begin
          r_job_wdata <= r_shadow[r_tx_idx];
          r_tx_idx    <= r_tx_idx + 1'b1;
        end else begin
          r_job_wen  <= 1'b0;
          r_tx_idx   <= '0;
          r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX: issue RESULT_WORDS reads back to back; r_cap marks the cycle the
  // FIFO data for the previous read strobe is on i_res_rdata.
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_iss    <= '0;
      r_res_ren   <= 1'b0;
      r_cap       <= 1'b0;
      r_cap_idx   <= '0;
      r_res_valid <= 1'b0;
      for (int k = 0; k < RESULT_WORDS; k++) r_result[k] <= '0;
    end else begin
      r_cap <= r_res_ren;
      if (w_pop_ok) r_res_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (!r_res_valid && i_res_r_ready) begin
          r_rx_state <= RX_READ;
          r_res_ren  <= 1'b1;
          r_rx_iss   <= RXW'(1);
        end
        default: if (r_rx_iss != RX_ISS) r_rx_iss  <= r_rx_iss + 1'b1;
                 else                    r_res_ren <= 1'b0;
      endcase
      if (r_cap) begin
        r_result[r_cap_idx] <= i_res_rdata;
        if (r_cap_idx == RX_LAST) begin
          r_cap_idx   <= '0;
          r_res_valid <= 1'b1;
          r_rx_state  <= RX_IDLE;
        end else begin
          r_cap_idx <= r_cap_idx + 1'b1;
        end
      end
    end
  end

`ifdef CSA_JOB_PORT_CNT_EN
  // Activity counters; a clear write wins over a same-cycle increment
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      r_cnt_jobs <= '0;
      r_cnt_res  <= '0;
    end else if (i_wen && (i_waddr == ADDR_CNT_JOBS)) begin
      r_cnt_jobs <= '0;
      r_cnt_res  <= '0;
    end else begin
      if (w_push_done) r_cnt_jobs <= r_cnt_jobs + 1'b1;
      if (w_pop_ok)    r_cnt_res  <= r_cnt_res + 1'b1;
    end
  end
`endif

  // Read mux; unmapped addresses return an 0xE000 tag plus the address
  always_comb begin
    w_rdata = {16'hE000, {(AXI_DATA_WIDTH-16-OPT_MEM_ADDR_BITS){1'b0}}, i_raddr};
    for (int k = 0; k < JOB_WORDS; k++)
      if (i_raddr == OPT_MEM_ADDR_BITS'(k)) w_rdata = r_stage[k];
    for (int k = 0; k < RESULT_WORDS; k++)
      if (i_raddr == OPT_MEM_ADDR_BITS'(JOB_WORDS + 3 + k)) w_rdata = r_result[k];
    if (i_raddr == ADDR_STATUS)
      w_rdata = {{(AXI_DATA_WIDTH-4){1'b0}}, r_ovf, i_job_w_ready, r_res_valid, w_tx_busy};
`ifdef CSA_JOB_PORT_CNT_EN
    if (i_raddr == ADDR_CNT_JOBS) w_rdata = r_cnt_jobs;
    if (i_raddr == ADDR_CNT_RES)  w_rdata = r_cnt_res;
`endif
  end

  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n)     r_rdata <= '0;
    else if (i_ren) r_rdata <= w_rdata;
  end

endmodule

// File: tb/tb_csa_job_port.sv
module tb_csa_job_port;
  logic        axi_mm_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [9:0]  waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        job_w_ready = 1'b0;
  logic        job_wen;
  logic [31:0] job_wdata;
  logic        res_r_ready = 1'b0;
  logic        res_ren;
  logic [31:0] res_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] got_job[$];
  logic [31:0] fifo_q[$];
  bit          rx_en = 1'b0;
  int          res_cnt = 0;

  // Reference state kept at record level
  logic [31:0] stage_m [5];
  logic [31:0] exp_job [5];
  logic [31:0] rec1 [7];
  logic [31:0] rec2 [7];
  int          jobs_m = 0;
  int          pops_m = 0;

  csa_job_port dut (
    .axi_mm_clk   (axi_mm_clk),
    .rst_n        (rst_n),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_wstrb      (wstrb),
    .i_ren        (ren),
    .i_raddr      (raddr),
    .o_rdata      (rdata),
    .i_job_w_ready(job_w_ready),
    .o_job_wen    (job_wen),
    .o_job_wdata  (job_wdata),
    .i_res_r_ready(res_r_ready),
    .o_res_ren    (res_ren),
    .i_res_rdata  (res_rdata)
  );

  always #5 axi_mm_clk = ~axi_mm_clk;

  // Output-FIFO model: registered read data, ready when a full record is held
  always @(posedge axi_mm_clk) begin
    if (res_ren && fifo_q.size() > 0) res_rdata <= fifo_q.pop_front();
    res_r_ready <= rx_en && (fifo_q.size() >= 7);
  end

  // Monitors, sampled mid-cycle
  always @(negedge axi_mm_clk) begin
    if (job_wen) got_job.push_back(job_wdata);
    if (res_ren) res_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge axi_mm_clk); #1;
    wen = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    ren = 1'b1; raddr = a;
    @(posedge axi_mm_clk); #1;
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic wait_words(input int n, input string tag);
    int t = 0;
    while (got_job.size() < n && t < 100) begin
      @(posedge axi_mm_clk); #1; t++;
    end
    repeat (3) @(posedge axi_mm_clk);
    #1;
    chk(tag, got_job.size(), n);
  endtask

  task automatic wait_valid(input string tag);
    logic [31:0] s;
    int t = 0;
    s = '0;
    while (t < 60) begin
      rd(10'd6, s);
      if (s[1]) break;
      t++;
    end
    chk(tag, {31'd0, s[1]}, 32'd1);
  endtask

  task automatic write_stage(input int k, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) stage_m[k][8*b +: 8] = d[8*b +: 8];
    wr(10'(k), d, s);
  endtask

  task automatic check_push(input string tag);
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s_w%0d", tag, k), got_job[k], exp_job[k]);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] s;
    for (int k = 0; k < 5; k++) stage_m[k] = '0;

    // Reset state
    repeat (3) @(posedge axi_mm_clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_job_wen", {31'd0, job_wen}, 32'd0);
    chk("rst_job_wdata", job_wdata, 32'h0);
    chk("rst_res_ren", {31'd0, res_ren}, 32'd0);
    rst_n = 1'b1;
    @(posedge axi_mm_clk); #1;
    rd(10'd6, d);
    chk("rst_status", d, 32'h0);

    // Basic job 1..5 with FIFO ready
    job_w_ready = 1'b1;
    for (int k = 0; k < 5; k++) write_stage(k, 32'(k + 1), 4'hF);
    exp_job = stage_m;
    wr(10'd5, 32'h1, 4'hF);
    rd(10'd6, d);
    chk("busy_set", {31'd0, d[0]}, 32'd1);
    wait_words(5, "push1_count");
    check_push("push1");
    jobs_m++;
    rd(10'd6, d);
    chk("busy_clear", {31'd0, d[0]}, 32'd0);

    // Randomized staging contents and byte masks
    for (int j = 0; j < 3; j++) begin
      got_job.delete();
      for (int k = 0; k < 5; k++) write_stage(k, $urandom, 4'($urandom_range(0, 15)));
      for (int k = 0; k < 5; k++) begin
        rd(10'(k), d);
        chk($sformatf("stage_j%0d_%0d", j, k), d, stage_m[k]);
      end
      exp_job = stage_m;
      wr(10'd5, 32'h1, 4'hF);
      wait_words(5, $sformatf("rpush%0d_count", j));
      check_push($sformatf("rpush%0d", j));
      jobs_m++;
    end

    // Held off by FIFO, overflow on second commit, W1C, late ready
    got_job.delete();
    job_w_ready = 1'b0;
    for (int k = 0; k < 5; k++) write_stage(k, $urandom, 4'hF);
    exp_job = stage_m;
    wr(10'd5, 32'h1, 4'hF);
    repeat (10) @(posedge axi_mm_clk);
    #1;
    chk("hold_no_push", got_job.size(), 0);
    write_stage(0, 32'hDEAD_BEEF, 4'hF);
    wr(10'd5, 32'h1, 4'hF);
    rd(10'd6, d);
    chk("status_ovf", d, 32'h9);
    wr(10'd6, 32'h8, 4'hF);
    rd(10'd6, d);
    chk("status_w1c", d, 32'h1);
    job_w_ready = 1'b1;
    @(posedge axi_mm_clk); #1;
    chk("late_ready_wen", {31'd0, job_wen}, 32'd1);
    write_stage(1, 32'h1234_5678, 4'hF);
    wait_words(5, "late_count");
    check_push("late");
    jobs_m++;

    // Result drain
    for (int k = 0; k < 7; k++) begin rec1[k] = $urandom; fifo_q.push_back(rec1[k]); end
    rx_en = 1'b1;
    wait_valid("res1_valid");
    chk("res1_ren_count", res_cnt, 7);
    for (int k = 0; k < 7; k++) begin
      rd(10'(8 + k), d);
      chk($sformatf("res1_w%0d", k), d, rec1[k]);
    end
    for (int k = 0; k < 7; k++) begin rec2[k] = $urandom; fifo_q.push_back(rec2[k]); end
    repeat (20) @(posedge axi_mm_clk);
    #1;
    chk("res2_held", res_cnt, 7);
    rd(10'd8, d);
    chk("res1_kept", d, rec1[0]);
    wr(10'd7, 32'h1, 4'hF);
    pops_m++;
    wait_valid("res2_valid");
    chk("res2_ren_count", res_cnt, 14);
    for (int k = 0; k < 7; k++) begin
      rd(10'(8 + k), d);
      chk($sformatf("res2_w%0d", k), d, rec2[k]);
    end
    wr(10'd7, 32'h1, 4'hF);
    pops_m++;
    wr(10'd7, 32'h1, 4'hF);
    repeat (10) @(posedge axi_mm_clk);
    #1;
    rd(10'd6, d);
    chk("res_empty_valid", {31'd0, d[1]}, 32'd0);
    chk("res_empty_count", res_cnt, 14);

    // Byte strobes and unmapped reads
    write_stage(0, 32'h0, 4'hF);
    write_stage(0, 32'hAABB_CCDD, 4'b0010);
    rd(10'd0, d);
    chk("wstrb_partial", d, 32'h0000_CC00);
    rd(10'h20, d);
    chk("unmapped_20", d, 32'hE000_0020);
    rd(10'h3FF, d);
    chk("unmapped_3ff", d, 32'hE000_03FF);

`ifdef CSA_JOB_PORT_CNT_EN
    rd(10'd15, d);
    chk("cnt_jobs", d, 32'(jobs_m));
    rd(10'd16, d);
    chk("cnt_pops", d, 32'(pops_m));
    wr(10'd15, 32'h0, 4'hF);
    rd(10'd15, d);
    chk("cnt_jobs_clr", d, 32'h0);
    rd(10'd16, d);
    chk("cnt_pops_clr", d, 32'h0);
`else
    wr(10'd15, 32'hFFFF_FFFF, 4'hF);
    rd(10'd15, d);
    chk("nocnt_15", d, 32'hE000_000F);
    rd(10'd16, d);
    chk("nocnt_16", d, 32'hE000_0010);
`endif

    // Reset in the middle of a push
    got_job.delete();
    write_stage(2, 32'h5555_AAAA, 4'hF);
    wr(10'd5, 32'h1, 4'hF);
    s = 0;
    for (int t = 0; t < 20 && !job_wen; t++) begin @(posedge axi_mm_clk); #1; end
    chk("midpush_started", {31'd0, job_wen}, 32'd1);
    rst_n = 1'b0;
    @(posedge axi_mm_clk); #1;
    chk("midpush_wen_drop", {31'd0, job_wen}, 32'd0);
    rst_n = 1'b1;
    rd(10'd6, d);
    chk("midpush_status", d, 32'h4);
    rd(10'd2, d);
    chk("midpush_stage_rst", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
